sync_debounce_multi: RTL and testbench
======================================

Name: sync_debounce_multi

Overview:
Multi-channel successor to the two-flop synchronizer. Each channel has:
- a configurable-depth metastability chain;
- a per-channel debounce filter that accepts a level only after it has been stable for N cycles;
- registered rise, fall and change strobes.

It sits between board pins (buttons, switches, external strobes) and the core clock domain. It replaces ad-hoc synchronizer-plus-counter logic.

Parameters:
CHANNELS, 4, number of independent input bits.
STAGES, 2, synchronizer flop depth per channel; legal values are 2 or more.
DEBOUNCE_CYCLES, 1000, consecutive cycles a new synchronized level must persist before it is accepted; legal values are 1 or more (1 means no filtering beyond one cycle).
DEFAULT, {CHANNELS{1'b0}}, per-channel reset level for every synchronizer stage and for sync_output.

Ports:
clock  input  1  single system clock.
reset  input  1  asynchronous, active-high reset.
async_input  input  CHANNELS  raw asynchronous inputs.
sync_output  output  CHANNELS  debounced, synchronized level per channel.
rise_pulse  output  CHANNELS  one-cycle strobe when sync_output goes 0 to 1.
fall_pulse  output  CHANNELS  one-cycle strobe when sync_output goes 1 to 0.
changed  output  1  OR of all rise_pulse and fall_pulse bits, registered alongside them.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. It takes effect immediately, independent of clock. Release is synchronous to the reset tree owned elsewhere.
- Reset values:
  - all STAGES flops of channel i = DEFAULT[i];
  - sync_output = DEFAULT;
  - debounce counters = 0;
  - rise_pulse, fall_pulse = 0; changed = 0.
- Synchronizer: on each clock edge, stage1 <= async_input and stage k <= stage k-1. Call the last stage s.
- Debounce, per channel, evaluated each edge:
  - If s == sync_output: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: sync_output <= s and counter <= 0. Assert rise_pulse or fall_pulse for this channel in the same edge, chosen by the new value.
  - Else: counter <= counter+1.
- Pulse timing: pulses are registered and high for exactly one cycle. They deassert on the next edge unless a new acceptance occurs. Because the counter clears on acceptance, back-to-back acceptances on one channel are at least DEBOUNCE_CYCLES cycles apart.
- Counter width is clog2(DEBOUNCE_CYCLES). With DEBOUNCE_CYCLES=1, the counter is a constant 0 with no storage.
- Latency: an input change held steady is sampled into stage1 at edge 1. sync_output and the pulse update at edge STAGES+DEBOUNCE_CYCLES.
- Glitch rejection: any return of s to sync_output before the count completes clears the counter. No output change and no pulse occur.
- Channel independence: channels are fully independent. Simultaneous acceptances on several channels each pulse in the same cycle, and changed is 1 for that cycle.
- Reset mid-count: the counter is discarded and outputs return to DEFAULT. After release, input that still differs from DEFAULT needs a full STAGES+DEBOUNCE_CYCLES to be accepted.
- No combinational path from async_input to any output. All outputs come directly from flops.
- Elaboration-time error if STAGES<2, DEBOUNCE_CYCLES<1 or CHANNELS<1.

Decomposition:
- Shared util package: a clog2-based counter-width helper function. No typedefs needed.
- One natural sub-module, debounce_channel: one bit, holding the STAGES chain, counter, stable level and rise/fall flops.
- The top generates CHANNELS instances and registers changed as the OR of the next-state pulses.

Test Plan (STAGES=2, DEBOUNCE_CYCLES=4, CHANNELS=4 unless noted):
1. Reset with DEFAULT=4'b0101 -> immediately on reset assertion, without a clock edge: sync_output=4'b0101, all pulses 0. After release with inputs held at 4'b0101, no pulse ever.
2. Raise async_input[0] just before edge 1 and hold -> sync_output[0]=1 after edge 6, rise_pulse[0]=1 and changed=1 for exactly that one cycle, all other bits 0.
3. Glitch: async_input[1] high for 3 cycles, then low -> sync_output[1] stays 0 and no pulse. Repeat with 4 cycles high -> accepted, rise then later fall pulse, each a single cycle.
4. Drive inputs 0 and 2 from 0 to 1 on the same edge -> rise_pulse=4'b0101 in one cycle, changed=1 once.
5. Raise input 3 and assert reset asynchronously between clock edges at cycle 4 (mid-count) -> outputs at DEFAULT the instant reset rises. After release, output 3 rises exactly 6 edges later.
6. DEBOUNCE_CYCLES=1, STAGES=3: toggle input 0 every 5 cycles -> output follows with 4-edge latency, one pulse per toggle, alternating rise and fall.

Source files
------------

// File: rtl/sync_debounce_multi_pkg.sv
// Shared helpers for the multi-channel synchronizer/debouncer.
package sync_debounce_multi_pkg;

   function automatic int counter_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 0;
   endfunction

endpackage

// File: rtl/sync_debounce_multi_debounce_channel.sv
// One channel: metastability chain, stability counter, level and strobes.
module debounce_channel
   import sync_debounce_multi_pkg::*;
#(
   parameter int   STAGES          = 2,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic DEFAULT         = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_input,
   output logic sync_output,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic accept_rise,
   output logic accept_fall
);

   logic [STAGES-1:0] chain;
   logic              s;
   logic              accept;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chain <= {STAGES{DEFAULT}};
      end else begin
         chain <= {chain[STAGES-2:0], async_input};
      end
   end

   assign s = chain[STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 1) begin : g_nocnt
         assign accept = (s != sync_output);
      end else begin : g_cnt
         localparam int CW = counter_width(DEBOUNCE_CYCLES);
         localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0] count;

         // Any return to the held level restarts the stability window
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               count <= '0;
            end else if (s == sync_output || count == LAST) begin
               count <= '0;
            end else begin
               count <= count + CW'(1);
            end
         end

         assign accept = (s != sync_output) && (count == LAST);
      end
   endgenerate

   assign accept_rise = accept & s;
   assign accept_fall = accept & ~s;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_output <= DEFAULT;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
      end else begin
         if (accept) begin
            sync_output <= s;
         end
         rise_pulse <= accept_rise;
         fall_pulse <= accept_fall;
      end
   end

endmodule

// File: rtl/sync_debounce_multi.sv
// Multi-channel synchronizer with per-channel debounce and edge strobes.
module sync_debounce_multi
   import sync_debounce_multi_pkg::*;
#(
   parameter int                  CHANNELS        = 4,
   parameter int                  STAGES          = 2,
   parameter int                  DEBOUNCE_CYCLES = 1000,
   parameter logic [CHANNELS-1:0] DEFAULT         = {CHANNELS{1'b0}}
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] async_input,
   output logic [CHANNELS-1:0] sync_output,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                changed
);

   generate
      if (CHANNELS < 1) begin : g_bad_channels
         $error("CHANNELS must be at least 1");
      end
      if (STAGES < 2) begin : g_bad_stages
         $error("STAGES must be at least 2");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
         $error("DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   logic [CHANNELS-1:0] acc_rise;
   logic [CHANNELS-1:0] acc_fall;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STAGES          (STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DEFAULT         (DEFAULT[i])
      ) u_ch (
         .clock       (clock),
         .reset       (reset),
         .async_input (async_input[i]),
         .sync_output (sync_output[i]),
         .rise_pulse  (rise_pulse[i]),
         .fall_pulse  (fall_pulse[i]),
         .accept_rise (acc_rise[i]),
         .accept_fall (acc_fall[i])
      );
   end

   // Built from next-state strobes so it lines up with the pulse flops
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         changed <= 1'b0;
      end else begin
         changed <= |(acc_rise | acc_fall);
      end
   end

endmodule

// File: tb/tb_sync_debounce_multi.sv
// Bench for sync_debounce_multi: three configurations on one clock.
module tb_sync_debounce_multi;

   localparam int S = 2;
   localparam int D = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] ain_a, ain_b, ain_c;
   logic [3:0] so_a, rp_a, fp_a;
   logic [3:0] so_b, rp_b, fp_b;
   logic [3:0] so_c, rp_c, fp_c;
   logic       ch_a, ch_b, ch_c;

   always #5 clock = ~clock;

   sync_debounce_multi #(
      .CHANNELS(4), .STAGES(S), .DEBOUNCE_CYCLES(D), .DEFAULT(4'b0000)
   ) dut_a (
      .clock(clock), .reset(reset), .async_input(ain_a),
      .sync_output(so_a), .rise_pulse(rp_a), .fall_pulse(fp_a),
      .changed(ch_a)
   );

   sync_debounce_multi #(
      .CHANNELS(4), .STAGES(S), .DEBOUNCE_CYCLES(D), .DEFAULT(4'b0101)
   ) dut_b (
      .clock(clock), .reset(reset), .async_input(ain_b),
      .sync_output(so_b), .rise_pulse(rp_b), .fall_pulse(fp_b),
      .changed(ch_b)
   );

   sync_debounce_multi #(
      .CHANNELS(4), .STAGES(3), .DEBOUNCE_CYCLES(1), .DEFAULT(4'b0000)
   ) dut_c (
      .clock(clock), .reset(reset), .async_input(ain_c),
      .sync_output(so_c), .rise_pulse(rp_c), .fall_pulse(fp_c),
      .changed(ch_c)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference: input history per edge; a level is accepted when the
   // last D synchronized samples all differ from the held level and
   // the previous acceptance is at least D edges old.
   logic [3:0] hist_a[$];
   logic [3:0] hist_c[$];
   int         t;
   int         last_acc[4];
   logic [3:0] m_out, m_rise, m_fall;
   logic [3:0] c_prev;

   int rcnt_a[4], fcnt_a[4];
   int chg_cnt_a, both_cnt, rcnt_c, fcnt_c;

   function automatic logic s_at(input int e, input int ch);
      int idx = e - S;
      if (idx < 1) return 1'b0;
      return hist_a[idx-1][ch];
   endfunction

   task automatic model_reset();
      hist_a.delete();
      hist_c.delete();
      t = 0;
      for (int i = 0; i < 4; i++) last_acc[i] = -1000;
      m_out = '0;
      m_rise = '0;
      m_fall = '0;
      c_prev = '0;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         rcnt_a[i] = 0;
         fcnt_a[i] = 0;
      end
      chg_cnt_a = 0;
      both_cnt = 0;
      rcnt_c = 0;
      fcnt_c = 0;
   endtask

   task automatic tick();
      logic [3:0] c_exp, c_rise, c_fall;
      bit all;
      @(posedge clock);
      t++;
      hist_a.push_back(ain_a);
      hist_c.push_back(ain_c);
      m_rise = '0;
      m_fall = '0;
      for (int ch = 0; ch < 4; ch++) begin
         if (t - last_acc[ch] >= D) begin
            all = 1'b1;
            for (int j = 0; j < D; j++)
               if (s_at(t - j, ch) == m_out[ch]) all = 1'b0;
            if (all) begin
               m_out[ch] = ~m_out[ch];
               if (m_out[ch]) m_rise[ch] = 1'b1;
               else m_fall[ch] = 1'b1;
               last_acc[ch] = t;
            end
         end
      end
      c_exp = (t >= 4) ? hist_c[t-4] : 4'b0000;
      c_rise = c_exp & ~c_prev;
      c_fall = ~c_exp & c_prev;
      c_prev = c_exp;
      #1;
      check("a_sync", so_a, m_out);
      check("a_rise", rp_a, m_rise);
      check("a_fall", fp_a, m_fall);
      check("a_changed", ch_a, |(m_rise | m_fall));
      check("b_sync", so_b, 4'b0101);
      check("b_pulses", rp_b | fp_b, 4'b0000);
      check("b_changed", ch_b, 1'b0);
      check("c_sync", so_c, c_exp);
      check("c_rise", rp_c, c_rise);
      check("c_fall", fp_c, c_fall);
      check("c_changed", ch_c, |(c_rise | c_fall));
      for (int i = 0; i < 4; i++) begin
         rcnt_a[i] += int'(rp_a[i]);
         fcnt_a[i] += int'(fp_a[i]);
      end
      chg_cnt_a += int'(ch_a);
      if (rp_a == 4'b0101) both_cnt++;
      rcnt_c += int'(rp_c[0]);
      fcnt_c += int'(fp_c[0]);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   typedef struct {
      logic [3:0] ain;
      logic [3:0] so;
      logic [3:0] rp;
      logic [3:0] fp;
      logic       chg;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int first;
      ain_a = '0;
      ain_b = 4'b0101;
      ain_c = '0;
      model_reset();
      clear_counts();

      // Asynchronous reset before any clock edge
      #2 reset = 1'b1;
      #1;
      check("rst_a_sync", so_a, 4'b0000);
      check("rst_b_sync", so_b, 4'b0101);
      check("rst_b_pulses", rp_b | fp_b, 4'b0000);
      check("rst_b_changed", ch_b, 1'b0);
      check("rst_c_sync", so_c, 4'b0000);
      @(posedge clock);
      #1 reset = 1'b0;

      // Single rise on channel 0: accepted at edge S+D = 6
      for (int i = 0; i < 8; i++) begin
         tbl[i].ain = 4'b0001;
         tbl[i].so  = (i >= 5) ? 4'b0001 : 4'b0000;
         tbl[i].rp  = (i == 5) ? 4'b0001 : 4'b0000;
         tbl[i].fp  = 4'b0000;
         tbl[i].chg = (i == 5);
      end
      for (int i = 0; i < 8; i++) begin
         ain_a = tbl[i].ain;
         tick();
         check("tbl_sync", so_a, tbl[i].so);
         check("tbl_rise", rp_a, tbl[i].rp);
         check("tbl_fall", fp_a, tbl[i].fp);
         check("tbl_changed", ch_a, tbl[i].chg);
      end
      ain_a = '0;
      ticks(10);

      // Glitch of D-1 cycles is rejected
      clear_counts();
      ain_a[1] = 1'b1;
      ticks(3);
      ain_a[1] = 1'b0;
      ticks(12);
      check("glitch_rise", rcnt_a[1], 0);
      check("glitch_fall", fcnt_a[1], 0);

      // D cycles is accepted, then released
      clear_counts();
      ain_a[1] = 1'b1;
      ticks(4);
      ain_a[1] = 1'b0;
      ticks(12);
      check("hold4_rise", rcnt_a[1], 1);
      check("hold4_fall", fcnt_a[1], 1);

      // Two channels accepted on the same edge
      clear_counts();
      ain_a = 4'b0101;
      ticks(10);
      check("dual_rise", both_cnt, 1);
      check("dual_changed", chg_cnt_a, 1);
      ain_a = '0;
      ticks(10);

      // Reset asserted between edges in the middle of a count
      ain_a[3] = 1'b1;
      ticks(4);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_sync", so_a, 4'b0000);
      check("mid_rst_rise", rp_a, 4'b0000);
      check("mid_rst_changed", ch_a, 1'b0);
      check("mid_rst_b_sync", so_b, 4'b0101);
      model_reset();
      @(posedge clock);
      #1 reset = 1'b0;
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (first < 0 && rp_a[3]) first = k;
      end
      check("rst_latency", first, 6);
      ain_a = '0;
      ticks(10);

      // Unfiltered 3-stage channel toggling every 5 cycles
      clear_counts();
      for (int i = 0; i < 8; i++) begin
         ain_c[0] = ~ain_c[0];
         ticks(5);
      end
      ticks(6);
      check("c_toggle_rise", rcnt_c, 4);
      check("c_toggle_fall", fcnt_c, 4);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0)
            ain_a[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 3) == 0)
            ain_c[$urandom_range(0, 3)] ^= 1'b1;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
